// File: rtl/vga_rect_filler.sv
// Pixel-stream generator for a plot-style VGA sink: fills a clipped rectangle with a
// solid, striped or checkerboard colour, or free-runs full-screen colour sweeps.
module vga_rect_filler #(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic               CLOCK_50,
  input  logic [3:0]         KEY,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [X_W-1:0]     x0,
  input  logic [X_W-1:0]     w,
  input  logic [Y_W-1:0]     y0,
  input  logic [Y_W-1:0]     h,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               ready,
  output logic [X_W-1:0]     VGA_X,
  output logic [Y_W-1:0]     VGA_Y,
  output logic [COLOR_W-1:0] VGA_COLOR,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StSetup, StDraw, StDone} state_e;

  localparam logic [1:0] ModeStripes = 2'd1;
  localparam logic [1:0] ModeChecker = 2'd2;
  localparam logic [1:0] ModeSweep   = 2'd3;

  localparam logic [X_W:0] ScrW = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] ScrH = (Y_W+1)'(SCREEN_H);

  logic w_rst_n;
  logic w_unused_keys;
  assign w_rst_n       = KEY[0];
  assign w_unused_keys = ^KEY[3:2];

  state_e             r_state, w_state;
  logic [1:0]         r_mode;
  logic [X_W-1:0]     r_x0, r_w, r_xs, r_xe, r_x, w_x;
  logic [Y_W-1:0]     r_y0, r_h, r_ys, r_ye, r_y, w_y;
  logic [COLOR_W-1:0] r_color, r_sweep, w_sweep, r_pix_color, w_color;
  logic               r_plot, w_plot, r_busy, r_done;
  logic [1:0]         r_key1_sync;

  logic w_pause, w_accept, w_sweep_cmd, w_empty, w_last_x, w_last_y;

  // Last column/row of a clipped span: min(org + len, limit) - 1.
  function automatic logic [X_W-1:0] f_end_x(input logic [X_W-1:0] org, input logic [X_W-1:0] len);
    logic [X_W:0] sum;
    sum = {1'b0, org} + {1'b0, len};
    if (sum > ScrW) sum = ScrW;
    sum = sum - (X_W+1)'(1);
    return sum[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] f_end_y(input logic [Y_W-1:0] org, input logic [Y_W-1:0] len);
    logic [Y_W:0] sum;
    sum = {1'b0, org} + {1'b0, len};
    if (sum > ScrH) sum = ScrH;
    sum = sum - (Y_W+1)'(1);
    return sum[Y_W-1:0];
  endfunction

  function automatic logic [COLOR_W-1:0] f_color(input logic [1:0] m, input logic [X_W-1:0] dx,
                                                 input logic [Y_W-1:0] dy,
                                                 input logic [COLOR_W-1:0] base,
                                                 input logic [COLOR_W-1:0] sweep);
    logic [X_W+3:0]         dxe;
    logic [Y_W+COLOR_W+3:0] dye;
    dxe = {4'd0, dx};
    dye = {(COLOR_W+4)'(0), dy};
    case (m)
      ModeStripes: return base + dye[COLOR_W-1:0];
      ModeChecker: return (dxe[3] ^ dye[3]) ? ~base : base;
      ModeSweep:   return sweep;
      default:     return base;
    endcase
  endfunction

  assign w_pause     = ~r_key1_sync[1];
  assign w_accept    = r_plot & ready & ~w_pause;
  assign w_sweep_cmd = (r_mode == ModeSweep);
  assign w_last_x    = (r_x == r_xe);
  assign w_last_y    = (r_y == r_ye);
  assign w_empty     = (r_w == '0) || (r_h == '0) || ({1'b0, r_x0} >= ScrW) ||
                       ({1'b0, r_y0} >= ScrH);

  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_color = r_pix_color;
    w_plot  = 1'b0;
    w_sweep = r_sweep;
    unique case (r_state)
      StIdle: if (start) w_state = StSetup;
      StSetup: begin
        if (w_sweep_cmd) begin
          w_x     = '0;
          w_y     = '0;
          w_color = r_sweep;
          w_plot  = ~w_pause;
          w_state = StDraw;
        end else if (w_empty) begin
          w_state = StDone;
        end else begin
          w_x     = r_x0;
          w_y     = r_y0;
          w_color = r_color;
          w_plot  = ~w_pause;
          w_state = StDraw;
        end
      end
      StDraw: begin
        w_plot = ~w_pause;
        if (w_accept) begin
          if (!w_last_x) begin
            w_x     = r_x + X_W'(1);
            w_color = f_color(r_mode, w_x - r_xs, r_y - r_ys, r_color, r_sweep);
          end else if (!w_last_y) begin
            w_x     = r_xs;
            w_y     = r_y + Y_W'(1);
            w_color = f_color(r_mode, '0, w_y - r_ys, r_color, r_sweep);
          end else begin
            if (w_sweep_cmd) w_sweep = r_sweep + COLOR_W'(1);
            // A sweep keeps running only while the live mode input still requests it.
            if (w_sweep_cmd && (mode == ModeSweep)) begin
              w_x     = '0;
              w_y     = '0;
              w_color = w_sweep;
            end else begin
              w_state = StDone;
              w_plot  = 1'b0;
            end
          end
        end
      end
      StDone:  w_state = StIdle;
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= StIdle;
      r_mode      <= '0;
      r_x0        <= '0;
      r_w         <= '0;
      r_y0        <= '0;
      r_h         <= '0;
      r_color     <= '0;
      r_xs        <= '0;
      r_ys        <= '0;
      r_xe        <= '0;
      r_ye        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_pix_color <= '0;
      r_plot      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sweep     <= COLOR_W'(1);
      r_key1_sync <= 2'b11;
    end else begin
      r_key1_sync <= {r_key1_sync[0], KEY[1]};
      r_state     <= w_state;
      r_x         <= w_x;
      r_y         <= w_y;
      r_pix_color <= w_color;
      r_plot      <= w_plot;
      r_sweep     <= w_sweep;
      r_busy      <= (w_state == StSetup) || (w_state == StDraw);
      r_done      <= (w_state == StDone);
      if (r_state == StIdle && start) begin
        r_mode  <= mode;
        r_x0    <= x0;
        r_w     <= w;
        r_y0    <= y0;
        r_h     <= h;
        r_color <= color_in;
      end
      if (r_state == StSetup) begin
        r_xs <= w_sweep_cmd ? '0 : r_x0;
        r_ys <= w_sweep_cmd ? '0 : r_y0;
        r_xe <= w_sweep_cmd ? X_W'(SCREEN_W - 1) : f_end_x(r_x0, r_w);
        r_ye <= w_sweep_cmd ? Y_W'(SCREEN_H - 1) : f_end_y(r_y0, r_h);
      end
    end
  end

  assign VGA_X     = r_x;
  assign VGA_Y     = r_y;
  assign VGA_COLOR = r_pix_color;
  assign plot      = r_plot;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed plus randomized bench for vga_rect_filler; accepted pixels are compared
// against a pixel list built from the rectangle/colour rules.
module tb_vga_rect_filler;

  logic       clk = 1'b0;
  logic [3:0] key;
  logic       start, ready, plot, busy, done;
  logic [1:0] mode;
  logic [7:0] x0, w, vga_x;
  logic [6:0] y0, h, vga_y;
  logic [2:0] color_in, vga_color;

  always #5 clk = ~clk;

  vga_rect_filler dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .start    (start),
    .mode     (mode),
    .x0       (x0),
    .w        (w),
    .y0       (y0),
    .h        (h),
    .color_in (color_in),
    .ready    (ready),
    .VGA_X    (vga_x),
    .VGA_Y    (vga_y),
    .VGA_COLOR(vga_color),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int got_q[$];
  int exp_sweep;
  int done_cyc, first_plot, last_plot, done_cnt, busy_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int pk(input int x, input int y, input int c);
    return (x << 10) | (y << 3) | c;
  endfunction

  // Reference pixel list: raster order over the clipped rectangle, or whole frames.
  function automatic void build_exp(input int md, input int cx, input int cy, input int cw,
                                    input int ch, input int cc, input int nframes);
    int xend, yend, col;
    exp_q.delete();
    if (md == 3) begin
      for (int f = 0; f < nframes; f++)
        for (int y = 0; y < 120; y++)
          for (int x = 0; x < 160; x++) exp_q.push_back(pk(x, y, (exp_sweep + f) % 8));
    end else begin
      xend = (cx + cw < 160) ? cx + cw : 160;
      yend = (cy + ch < 120) ? cy + ch : 120;
      for (int y = cy; y < yend; y++)
        for (int x = cx; x < xend; x++) begin
          if (md == 0) col = cc;
          else if (md == 1) col = (cc + (y - cy)) % 8;
          else col = ((((x - cx) / 8) + ((y - cy) / 8)) % 2 == 1) ? ((~cc) & 7) : cc;
          exp_q.push_back(pk(x, y, col));
        end
    end
  endfunction

  task automatic cmp_pix(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, got_q[i], exp_q[i]);
  endtask

  task automatic run_cmd(input int md, input int cx, input int cy, input int cw, input int ch,
                         input int cc, input bit rnd, input int pause_at, input int drop_at,
                         input int budget);
    bit          kh[$];
    bit          pl_prev, acc_prev, acc;
    logic [17:0] prev;
    got_q.delete();
    done_cyc = -1; first_plot = -1; last_plot = -1; done_cnt = 0; busy_bad = 0;
    pl_prev = 1'b0; acc_prev = 1'b0; prev = '0;
    @(negedge clk);
    start = 1'b1; mode = md[1:0]; x0 = cx[7:0]; y0 = cy[6:0]; w = cw[7:0]; h = ch[6:0];
    color_in = cc[2:0]; key[1] = 1'b1;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    // kh[c+3] holds KEY[1] as driven for cycle c.
    kh = '{1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (pl_prev && !acc_prev) chk("hold", {vga_x, vga_y, vga_color}, prev);
      if (kh[c] == 1'b0) chk("pause_plot", plot, 1'b0);
      if (plot) begin
        if (first_plot < 0) first_plot = c;
        last_plot = c;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy !== (done_cyc < 0)) busy_bad++;
      start = 1'b0;
      if (c >= drop_at) mode = 2'd0;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      key[1] = (c >= pause_at && c < pause_at + 10) ? 1'b0 : 1'b1;
      kh.push_back(key[1]);
      acc = plot && ready && kh[c+1];
      if (acc) got_q.push_back(int'({vga_x, vga_y, vga_color}));
      prev = {vga_x, vga_y, vga_color};
      pl_prev = plot;
      acc_prev = acc;
      if (done) break;
    end
    chk("done_seen", done_cyc >= 0, 1'b1);
    chk("done_once", done_cnt, 1);
    chk("busy_profile", busy_bad, 0);
    @(negedge clk);
    chk("done_pulse_end", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_plot", plot, 1'b0);
  endtask

  initial begin
    int md, cx, cy, cw, ch, cc;
    key = 4'b0010; start = 1'b0; mode = 2'd0; x0 = '0; y0 = '0; w = '0; h = '0;
    color_in = '0; ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_color", vga_color, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    key[0] = 1'b1;
    exp_sweep = 1;

    // Basic solid rectangle with exact timing.
    build_exp(0, 10, 20, 4, 3, 5, 0);
    run_cmd(0, 10, 20, 4, 3, 5, 1'b0, 32'h7fffffff, 32'h7fffffff, 100);
    cmp_pix("solid");
    chk("solid_first_plot", first_plot, 2);
    chk("solid_last_plot", last_plot, 13);
    chk("solid_done_cyc", done_cyc, 14);

    // Clipped at bottom-right corner.
    build_exp(0, 158, 118, 5, 5, 3, 0);
    run_cmd(0, 158, 118, 5, 5, 3, 1'b0, 32'h7fffffff, 32'h7fffffff, 100);
    cmp_pix("clip");
    chk("clip_n", got_q.size(), 4);
    chk("clip_done_cyc", done_cyc, 6);

    // Off-screen origin: empty command.
    run_cmd(0, 170, 5, 4, 4, 1, 1'b0, 32'h7fffffff, 32'h7fffffff, 100);
    chk("empty_n", got_q.size(), 0);
    chk("empty_done_cyc", done_cyc, 2);

    // Randomized rectangles with random back-pressure.
    for (int i = 0; i < 5; i++) begin
      md = $urandom_range(0, 2); cx = $urandom_range(0, 170); cy = $urandom_range(0, 125);
      cw = $urandom_range(0, 20); ch = $urandom_range(0, 12); cc = $urandom_range(0, 7);
      build_exp(md, cx, cy, cw, ch, cc, 0);
      run_cmd(md, cx, cy, cw, ch, cc, 1'b1, 32'h7fffffff, 32'h7fffffff, 2000);
      cmp_pix("rand");
    end

    // Checkerboard with back-pressure and a 10-cycle pause.
    build_exp(2, 0, 0, 16, 16, 2, 0);
    run_cmd(2, 0, 0, 16, 16, 2, 1'b1, 60, 32'h7fffffff, 3000);
    cmp_pix("checker");
    if (got_q.size() > 136) begin
      chk("checker_8_0", got_q[8], pk(8, 0, 5));
      chk("checker_8_8", got_q[136], pk(8, 8, 2));
    end else chk("checker_len", got_q.size(), 256);

    // Stripes down a single column.
    build_exp(1, 0, 0, 1, 10, 6, 0);
    run_cmd(1, 0, 0, 1, 10, 6, 1'b0, 32'h7fffffff, 32'h7fffffff, 100);
    cmp_pix("stripes");
    if (got_q.size() > 2) chk("stripes_row2", got_q[2], pk(0, 2, 0));

    // Asynchronous reset during pixel 5 of a solid fill.
    @(negedge clk);
    start = 1'b1; mode = 2'd0; x0 = 8'd10; y0 = 7'd20; w = 8'd4; h = 7'd3; color_in = 3'd5;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_plot", plot, 1'b1);
    #2 key[0] = 1'b0;
    #1 chk("async_rst_out", {vga_x, vga_y, vga_color, plot, busy, done}, '0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", done, 1'b0);
    end
    key[0] = 1'b1;
    exp_sweep = 1;
    build_exp(0, 10, 20, 4, 3, 5, 0);
    run_cmd(0, 10, 20, 4, 3, 5, 1'b0, 32'h7fffffff, 32'h7fffffff, 100);
    cmp_pix("after_rst");
    chk("after_rst_done_cyc", done_cyc, 14);

    // Two sweep frames, mode dropped during the second.
    build_exp(3, 0, 0, 0, 0, 0, 2);
    run_cmd(3, 0, 0, 0, 0, 0, 1'b0, 32'h7fffffff, 20000, 40000);
    cmp_pix("sweep2");
    chk("sweep2_done_cyc", done_cyc, 2 * 19200 + 2);
    if (got_q.size() > 19200) begin
      chk("sweep_frame_end", got_q[19199], pk(159, 119, 1));
      chk("sweep_frame_wrap", got_q[19200], pk(0, 0, 2));
    end
    exp_sweep = 3;

    // Following single sweep frame continues the colour sequence.
    build_exp(3, 0, 0, 0, 0, 0, 1);
    run_cmd(3, 0, 0, 0, 0, 0, 1'b0, 32'h7fffffff, 1, 20000);
    cmp_pix("sweep1");
    if (got_q.size() > 0) chk("sweep1_color", got_q[0] & 7, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rect_filler.md
# vga_rect_filler

Parametrised pixel-stream generator for the DESim "VGA" pixel-plot interface: it fills a clipped rectangle with a solid, striped or checkerboard colour, or free-runs a full-screen colour sweep with a new colour each frame. It drives `VGA_X`/`VGA_Y`/`VGA_COLOR`/`plot` directly, or through a `ready` back-pressure signal when it shares the plot port with other drawing engines. It is the generalised successor of the fixed 160×120, 3-bit full-screen sweep: screen size, coordinate widths and colour depth are parameters, and it adds command handshaking, back-pressure and a pause input.

## Interface
- `X_W`, 8, column coordinate width
- `Y_W`, 7, row coordinate width
- `COLOR_W`, 3, colour width (must be ≥ 1)
- `SCREEN_W`, 160, visible columns (≤ 2^X_W)
- `SCREEN_H`, 120, visible rows (≤ 2^Y_W)

- `CLOCK_50`  in  1  sole clock, 50 MHz, all logic on rising edge
- `KEY`  in  4  `KEY[0]` is the reset: asynchronous, active-low. `KEY[1]` is an active-low pause. `KEY[3:2]` are unused.
- `start`  in  1  command strobe; sampled only in IDLE
- `mode`  in  2  0 SOLID, 1 STRIPES, 2 CHECKER, 3 SWEEP
- `x0`, `w`  in  X_W each  rectangle origin column and width
- `y0`, `h`  in  Y_W each  rectangle origin row and height
- `color_in`  in  COLOR_W  base colour
- `ready`  in  1  the sink accepts a pixel when `plot & ready`
- `VGA_X`  out  X_W  pixel column
- `VGA_Y`  out  Y_W  pixel row
- `VGA_COLOR`  out  COLOR_W  pixel colour
- `plot`  out  1  pixel valid
- `busy`  out  1  high in SETUP and DRAW
- `done`  out  1  one-cycle completion pulse

## Operation
- All outputs are registered. On reset: `VGA_X`=0, `VGA_Y`=0, `VGA_COLOR`=0, `plot`=0, `busy`=0, `done`=0, state=IDLE, sweep colour=1.
- `KEY[1]` passes through a 2-flop synchroniser before use. Reset clears both flops to 1 (not paused).
- **Command capture:** in IDLE, `start`=1 latches `mode`, `x0`, `y0`, `w`, `h` and `color_in`. The FSM then goes to SETUP. `start` is ignored in every other state.
- **SETUP** (one cycle):
  - SWEEP: the bounds become (0,0) to (SCREEN_W-1, SCREEN_H-1).
  - Other modes: `xe = min(x0+w, SCREEN_W) - 1`, computed X_W+1 bits wide. `ye` is computed the same way from `y0`, `h` and SCREEN_H.
  - Empty command (`w`=0, `h`=0, `x0`≥SCREEN_W or `y0`≥SCREEN_H): go to DONE with no plot.
  - Otherwise: load the first pixel, assert `plot`, go to DRAW.
- **DRAW:** raster order, x fastest. A pixel advances only on `plot & ready & ~pause`.
  - While `plot`=1 and the pixel is not accepted, `VGA_X`, `VGA_Y` and `VGA_COLOR` hold stable.
  - While pause is active, `plot`=0 and all counters hold.
- **Colour per pixel** (dx = x−x0, dy = y−y0):
  - SOLID: `color_in`.
  - STRIPES: `color_in + dy[COLOR_W-1:0]`, modulo 2^COLOR_W.
  - CHECKER: `dx[3]^dy[3] ? ~color_in : color_in`.
  - SWEEP: the sweep colour register.
- **End of pixel run:** the last pixel is accepted at (xe, ye).
  - Non-SWEEP: go to DONE.
  - SWEEP: the sweep colour increments, modulo 2^COLOR_W, and the next frame starts at (0,0) with no gap cycle. If live `mode`≠3 at that moment, go to DONE instead; the colour still increments.
- **DONE** (one cycle): `done`=1, `busy`=0, `plot`=0. Always goes to IDLE next.
- The sweep colour persists across commands and is cleared to 1 only by reset.
- Reset asserted mid-frame aborts immediately to reset values. No `done` is produced.

## Timing
- `start` at cycle 0 → SETUP at cycle 1 → first `plot` at cycle 2.
- With `ready`=1 and no pause, one pixel is accepted per cycle. A w×h rectangle plots on cycles 2 … w·h+1, and `done` is high on cycle w·h+2.
- An empty command gives `done` on cycle 2.
- The earliest next `start` is accepted on cycle w·h+3 (IDLE).
- SWEEP frames are SCREEN_W·SCREEN_H accepted pixels each, back-to-back.

## Test plan
- Reset and command: hold `KEY[0]`=0, then release. Pulse `start`, SOLID, (10,20), w=4, h=3, color 5, `ready`=1 → 12 plots on cycles 2–13 covering x 10–13, y 20–22, colour 5. `done` on cycle 14 only; `busy` high on cycles 1–13.
- Clipping: SOLID at (158,118), w=5, h=5 → exactly 4 pixels, (158,118), (159,118), (158,119), (159,119). A separate command with `x0`=170 → no plot, `done` on cycle 2.
- Back-pressure and pause: CHECKER at (0,0), 16×16, color 2. Toggle `ready` randomly and hold `KEY[1]` low for 10 cycles mid-run → 256 accepted pixels. Outputs are stable while stalled, and `plot`=0 during the pause. Pixel (8,0) is colour 5 and pixel (8,8) is colour 2.
- STRIPES: (0,0), 1×10, color 6 → rows 0–9 have colours 6,7,0,1,2,3,4,5,6,7.
- SWEEP: after reset, run 2 full frames, then drop `mode` to 0 → frame 1 is colour 1 and frame 2 is colour 2, with pixel 19200 being (159,119) followed immediately by (0,0). `done` comes after the frame 2 end. A following sweep starts at colour 3.
- Mid-run reset: assert `KEY[0]` during SOLID pixel 5 → all outputs go to 0 asynchronously, no `done`. A new command after release executes normally.
